// File: rtl/median9_seq.sv
// Sequential 3x3 median stage.
// Nine serially streamed pixels are captured into a register bank, then a single
// shared compare-exchange unit runs five bubble passes of eight steps each. After
// pass k the k largest values sit sorted at the top of the bank, so after five
// passes slot 4 holds the 5th-smallest value, i.e. the median.
module median9_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [WIDTH-1:0] DI,
  input  logic             DSI,
  output logic [WIDTH-1:0] DO,
  output logic             DSO,
  output logic             BUSY
);

  typedef enum logic [1:0] {StIdle, StLoad, StCompute, StDone} state_e;

  localparam logic [5:0] LastCycle = 6'd39;

  state_e           state_q, state_d;
  logic [3:0]       count_q, count_d;
  logic [5:0]       cyc_q, cyc_d;
  logic             busy_q, busy_d;
  logic             dso_q, dso_d;
  logic [WIDTH-1:0] med_q, med_d;
  logic [WIDTH-1:0] win_q [9];

  logic             capture;
  logic             exchange;
  logic             last_step;
  logic [2:0]       step;
  logic [WIDTH-1:0] cx_a, cx_b, cx_max, cx_min;

  assign DO   = med_q;
  assign DSO  = dso_q;
  assign BUSY = busy_q;

  // Samples are accepted in every state except COMPUTE; DONE accepts the next window.
  assign capture   = DSI && (state_q != StCompute);
  assign exchange  = (state_q == StCompute);
  assign last_step = exchange && (cyc_q == LastCycle);
  // Each pass walks pairs (0,1) .. (7,8); the pass number is implicit in cyc_q[5:3].
  assign step      = cyc_q[2:0];

  // State register.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (DSI) state_d = StLoad;
      StLoad: begin
        if (!DSI) begin
          state_d = StIdle;
        end else if (count_q == 4'd8) begin
          state_d = StCompute;
        end
      end
      StCompute: if (last_step) state_d = StDone;
      StDone:    state_d = DSI ? StLoad : StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Counter and registered-output next values.
  always_comb begin
    count_d = count_q;
    cyc_d   = cyc_q;
    busy_d  = busy_q;
    dso_d   = 1'b0;
    med_d   = med_q;
    unique case (state_q)
      StIdle, StDone: begin
        count_d = DSI ? 4'd1 : 4'd0;
        busy_d  = DSI;
      end
      StLoad: begin
        if (DSI) begin
          count_d = count_q + 4'd1;
          cyc_d   = 6'd0;
        end else begin
          // Short window: drop it silently.
          count_d = 4'd0;
          busy_d  = 1'b0;
        end
      end
      StCompute: begin
        cyc_d = cyc_q + 6'd1;
        if (last_step) begin
          // Slot 4 is already final; the last step only touches slots 7 and 8.
          med_d   = win_q[4];
          dso_d   = 1'b1;
          busy_d  = 1'b0;
          count_d = 4'd0;
        end
      end
      default: begin
        count_d = 4'd0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Shared compare-exchange unit operand select.
  always_comb begin
    cx_a = '0;
    cx_b = '0;
    for (int i = 0; i < 8; i++) begin
      if (step == 3'(i)) begin
        cx_a = win_q[i];
        cx_b = win_q[i+1];
      end
    end
    cx_max = (cx_a > cx_b) ? cx_a : cx_b;
    cx_min = (cx_a > cx_b) ? cx_b : cx_a;
  end

  // Register bank: serial capture, or write-back of the compare-exchange result.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      for (int i = 0; i < 9; i++) win_q[i] <= '0;
    end else begin
      for (int i = 0; i < 9; i++) begin
        if (capture && (count_q == 4'(i))) begin
          win_q[i] <= DI;
        end else if (exchange && (i < 8) && (step == 3'(i))) begin
          win_q[i] <= cx_min;
        end else if (exchange && (i > 0) && (step == 3'(i - 1))) begin
          win_q[i] <= cx_max;
        end
      end
    end
  end

  // Counters and registered outputs.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      count_q <= 4'd0;
      cyc_q   <= 6'd0;
      busy_q  <= 1'b0;
      dso_q   <= 1'b0;
      med_q   <= '0;
    end else begin
      count_q <= count_d;
      cyc_q   <= cyc_d;
      busy_q  <= busy_d;
      dso_q   <= dso_d;
      med_q   <= med_d;
    end
  end

endmodule

// File: tb/tb_median9_seq.sv
// Scoreboard bench for median9_seq: the driver pushes the sorted-rank-5 value and
// the capture edge of every complete window; the monitor pops on each DSO.
module tb_median9_seq;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             nrst;
  logic [WIDTH-1:0] di;
  logic             dsi;
  logic [WIDTH-1:0] dout;
  logic             dso;
  logic             busy;

  median9_seq #(.WIDTH(WIDTH)) dut (
    .CLK  (clk),
    .nRST (nrst),
    .DI   (di),
    .DSI  (dsi),
    .DO   (dout),
    .DSO  (dso),
    .BUSY (busy)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int nwin  = 0;
  int ndso  = 0;

  logic [WIDTH-1:0] exp_q [$];
  int               e9_q  [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input logic d, input logic [WIDTH-1:0] v);
    dsi = d;
    di  = v;
    @(posedge clk);
    #1;
  endtask

  // Nine consecutive samples, then fill cycles covering COMPUTE (noisy = random DSI/DI).
  task automatic run_window(input logic [WIDTH-1:0] w [9], input int fill, input bit noisy,
                            input bit expect_out);
    logic [WIDTH-1:0] s [$];
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, w[i]);
      s.push_back(w[i]);
    end
    if (expect_out) begin
      s.sort();
      exp_q.push_back(s[4]);
      e9_q.push_back(cyc);
      nwin++;
    end
    for (int i = 0; i < fill; i++) begin
      if (noisy) drive(1'($urandom_range(0, 1)), WIDTH'($urandom));
      else       drive(1'b0, 'x);
    end
  endtask

  // Monitor: pops expectations on every DSO and checks timing and hold behaviour.
  logic             prev_dso = 1'b0;
  logic [WIDTH-1:0] last_med = '0;
  always @(negedge clk) begin
    if (dso) begin
      ndso++;
      if (prev_dso) chk("dso_width", 2, 1);
      if (exp_q.size() == 0) begin
        chk("unexpected_dso", 1, 0);
      end else begin
        last_med = exp_q.pop_front();
        chk("median", int'(dout), int'(last_med));
        chk("dso_time", cyc, e9_q.pop_front() + 40);
        chk("busy_at_dso", int'(busy), 0);
      end
    end else if (prev_dso) begin
      chk("do_hold", int'(dout), int'(last_med));
    end
    prev_dso = dso;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] w [9];
    int k;
    dsi  = 1'b0;
    di   = '0;
    nrst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_do", int'(dout), 0);
    chk("rst_dso", int'(dso), 0);
    chk("rst_busy", int'(busy), 0);
    nrst = 1'b1;

    // Ascending window, busy checked mid-compute.
    w = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    run_window(w, 20, 1'b0, 1'b1);
    chk("busy_compute", int'(busy), 1);
    repeat (22) drive(1'b0, 'x);

    w = '{9, 8, 7, 6, 5, 4, 3, 2, 1};
    run_window(w, 42, 1'b0, 1'b1);
    w = '{200, 200, 200, 200, 200, 200, 200, 200, 200};
    run_window(w, 42, 1'b0, 1'b1);
    w = '{0, 255, 0, 255, 0, 255, 0, 255, 7};
    run_window(w, 42, 1'b0, 1'b1);
    w = '{255, 255, 255, 255, 255, 255, 255, 255, 255};
    run_window(w, 42, 1'b0, 1'b1);

    // Partial window is dropped.
    repeat (5) drive(1'b1, 8'd99);
    chk("busy_partial", int'(busy), 1);
    drive(1'b0, 'x);
    chk("busy_drop", int'(busy), 0);
    w = '{10, 20, 30, 40, 50, 60, 70, 80, 90};
    run_window(w, 42, 1'b0, 1'b1);

    // Reset at compute cycle 20 aborts the window.
    w = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    run_window(w, 20, 1'b0, 1'b0);
    nrst = 1'b0;
    drive(1'b0, 'x);
    nrst = 1'b1;
    chk("abort_do", int'(dout), 0);
    chk("abort_dso", int'(dso), 0);
    chk("abort_busy", int'(busy), 0);
    repeat (45) drive(1'b0, 'x);
    w = '{3, 3, 3, 1, 1, 1, 2, 2, 2};
    run_window(w, 42, 1'b0, 1'b1);

    // DSI/DI noise through compute, then a back-to-back window from the DSO cycle.
    w = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    run_window(w, 40, 1'b1, 1'b1);
    w = '{50, 51, 52, 53, 54, 55, 56, 57, 58};
    run_window(w, 42, 1'b0, 1'b1);

    // Random windows with gaps, partial windows and compute noise.
    for (int n = 0; n < 1000; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        k = $urandom_range(1, 8);
        repeat (k) drive(1'b1, WIDTH'($urandom));
        drive(1'b0, 'x);
      end
      for (int i = 0; i < 9; i++) begin
        w[i] = $urandom_range(0, 1) ? WIDTH'($urandom) : WIDTH'($urandom_range(0, 3));
      end
      run_window(w, 40, 1'($urandom_range(0, 1)), 1'b1);
      repeat ($urandom_range(0, 2)) drive(1'b0, 'x);
    end

    // Drain, bounded.
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) drive(1'b0, 'x);
    repeat (2) drive(1'b0, 'x);
    chk("drain", exp_q.size(), 0);
    chk("dso_count", ndso, nwin);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
